// File: rtl/tpg_cfg_sequencer.sv
// AXI4-Lite write-only master that programs the TPG: height, width,
// background pattern, then CTRL (ap_start | auto_restart). A stop request
// writes 0x00 to CTRL. One outstanding write at a time, no timeouts.
module tpg_cfg_sequencer #(
    parameter int unsigned       ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       START_DLY = 8,
    parameter int unsigned       GAP_DLY   = 8,
    parameter logic [7:0]        CTRL_RUN  = 8'h81
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic [15:0]       cfg_height,
    input  logic [15:0]       cfg_width,
    input  logic [7:0]        cfg_pattern,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready
);

    typedef enum logic [2:0] {
        S_IDLE, S_DLY, S_ISSUE, S_WAIT_B, S_GAP, S_FIN
    } state_t;

    localparam logic [ADDR_W-1:0] OFF_H     = ADDR_W'(8'h10);
    localparam logic [ADDR_W-1:0] OFF_W     = ADDR_W'(8'h18);
    localparam logic [ADDR_W-1:0] OFF_BG    = ADDR_W'(8'h20);
    localparam logic [ADDR_W-1:0] OFF_CTRL  = ADDR_W'(8'h00);
    localparam logic [15:0]       START_CNT = 16'(START_DLY);
    localparam logic [15:0]       GAP_CNT   = 16'(GAP_DLY);

    state_t            r_state;
    state_t            w_next;
    logic [15:0]       r_cnt;
    logic [1:0]        r_idx;
    logic              r_stop_mode;
    logic              r_stop_pend;
    logic [15:0]       r_h;
    logic [15:0]       r_w;
    logic [7:0]        r_p;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic              r_awvalid;
    logic              r_wvalid;
    logic              r_bready;
    logic [ADDR_W-1:0] r_awaddr;
    logic [31:0]       r_wdata;
    logic              r_issued;
    logic              r_aw_ok;
    logic              r_w_ok;

    logic              w_size_ok;
    logic              w_aw_fin;
    logic              w_w_fin;
    logic              w_b_fire;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_data;

    assign w_size_ok = (cfg_height != 16'd0) && (cfg_width != 16'd0);
    // a channel counts as finished once it handshook earlier or is handshaking now
    assign w_aw_fin  = r_aw_ok | (r_awvalid & m_axi_awready);
    assign w_w_fin   = r_w_ok  | (r_wvalid  & m_axi_wready);
    assign w_b_fire  = r_bready & m_axi_bvalid;

    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;

    // register address/data selected by the write index
    always_comb begin
        w_addr = BASE_ADDR + OFF_CTRL;
        w_data = '0;
        case (r_idx)
            2'd0:    begin w_addr = BASE_ADDR + OFF_H;  w_data = {16'h0, r_h}; end
            2'd1:    begin w_addr = BASE_ADDR + OFF_W;  w_data = {16'h0, r_w}; end
            2'd2:    begin w_addr = BASE_ADDR + OFF_BG; w_data = {24'h0, r_p}; end
            default: begin
                w_addr = BASE_ADDR + OFF_CTRL;
                w_data = r_stop_mode ? 32'h0 : {24'h0, CTRL_RUN};
            end
        endcase
    end

    // state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cfg_stop)                    w_next = S_ISSUE;
                else if (cfg_start && w_size_ok) w_next = S_DLY;
            end
            S_DLY:   if (r_cnt <= 16'd1) w_next = S_ISSUE;
            S_ISSUE: if (r_issued && w_aw_fin && w_w_fin) w_next = S_WAIT_B;
            S_WAIT_B: begin
                if (w_b_fire) begin
                    if (m_axi_bresp != 2'b00)            w_next = S_IDLE;
                    else if (r_stop_pend && !r_stop_mode) w_next = S_ISSUE;
                    else if (r_idx < 2'd2)               w_next = S_ISSUE;
                    else if (r_idx == 2'd2)              w_next = S_GAP;
                    else                                 w_next = S_FIN;
                end
            end
            S_GAP:   if (r_cnt <= 16'd1) w_next = S_ISSUE;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // datapath, AXI channel registers and status flags
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_stop_mode <= 1'b0;
            r_stop_pend <= 1'b0;
            r_h         <= '0;
            r_w         <= '0;
            r_p         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_issued    <= 1'b0;
            r_aw_ok     <= 1'b0;
            r_w_ok      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // a stop arriving mid-sequence is honoured after the current B
            if (r_state != S_IDLE && cfg_stop) r_stop_pend <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (cfg_stop) begin
                        r_error     <= 1'b0;
                        r_idx       <= 2'd3;
                        r_stop_mode <= 1'b1;
                        r_stop_pend <= 1'b0;
                        r_busy      <= 1'b1;
                    end else if (cfg_start) begin
                        if (!w_size_ok) begin
                            r_error <= 1'b1;
                        end else begin
                            r_h         <= cfg_height;
                            r_w         <= cfg_width;
                            r_p         <= cfg_pattern;
                            r_error     <= 1'b0;
                            r_idx       <= 2'd0;
                            r_stop_mode <= 1'b0;
                            r_stop_pend <= 1'b0;
                            r_busy      <= 1'b1;
                            r_cnt       <= START_CNT;
                        end
                    end
                end
                S_DLY, S_GAP: begin
                    r_cnt <= (r_cnt == 16'd0) ? 16'd0 : r_cnt - 16'd1;
                    if (r_state == S_GAP && r_cnt <= 16'd1) r_idx <= 2'd3;
                end
                S_ISSUE: begin
                    if (!r_issued) begin
                        // valids rise one cycle after entering ISSUE
                        r_issued  <= 1'b1;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_awaddr  <= w_addr;
                        r_wdata   <= w_data;
                    end else begin
                        if (r_awvalid && m_axi_awready) begin
                            r_awvalid <= 1'b0;
                            r_aw_ok   <= 1'b1;
                        end
                        if (r_wvalid && m_axi_wready) begin
                            r_wvalid <= 1'b0;
                            r_w_ok   <= 1'b1;
                        end
                        if (w_aw_fin && w_w_fin) begin
                            r_bready <= 1'b1;
                            r_issued <= 1'b0;
                            r_aw_ok  <= 1'b0;
                            r_w_ok   <= 1'b0;
                        end
                    end
                end
                S_WAIT_B: begin
                    if (w_b_fire) begin
                        r_bready <= 1'b0;
                        if (m_axi_bresp != 2'b00) begin
                            r_error     <= 1'b1;
                            r_busy      <= 1'b0;
                            r_stop_pend <= 1'b0;
                            r_stop_mode <= 1'b0;
                        end else if (r_stop_pend && !r_stop_mode) begin
                            r_stop_pend <= 1'b0;
                            r_stop_mode <= 1'b1;
                            r_idx       <= 2'd3;
                        end else if (r_idx < 2'd2) begin
                            r_idx <= r_idx + 2'd1;
                        end else if (r_idx == 2'd2) begin
                            r_cnt <= GAP_CNT;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    r_busy      <= 1'b0;
                    r_stop_pend <= 1'b0;
                    r_stop_mode <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tpg_cfg_sequencer.sv
// Bench for tpg_cfg_sequencer: randomizing AXI4-Lite slave plus a
// write-list model derived from the command (start/stop, sizes, error
// position, stop position), checked every cycle by one negedge process.
module tb_tpg_cfg_sequencer;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cfg_start = 1'b0, cfg_stop = 1'b0;
    logic [15:0] cfg_height = '0, cfg_width = '0;
    logic [7:0]  cfg_pattern = '0;
    logic        busy, done, error;
    logic [11:0] m_axi_awaddr;
    logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready;
    logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp = 2'b00;

    tpg_cfg_sequencer dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_height(cfg_height), .cfg_width(cfg_width), .cfg_pattern(cfg_pattern),
        .busy(busy), .done(done), .error(error),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    always #5 aclk = ~aclk;

    int total = 0, bad = 0;
    int cyc = 0;
    always @(posedge aclk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // model outputs: expected write list and end-of-command status
    logic [11:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic        exp_err, exp_done;
    int          err_at = -1;
    int          mode = 0;
    int          cmd_seq = 0;
    int          st_cyc = 0;

    // monitor/slave state (written only by the negedge process)
    int          last_seq = 0, aw_i = 0, w_i = 0, wr_num = 0, done_cnt = 0, n_rise = 0, n_b = 0;
    int          rise_cyc[8], b_cyc[8];
    logic [11:0] cap_addr[8];
    logic [31:0] cap_data[8];
    bit          saw_split = 0;
    bit          aw_got = 0, w_got = 0, aw_f = 0, w_f = 0, b_f = 0, pv_aw = 0, pv_w = 0;
    int          b_wait = 0, w_wait = 0;
    logic [11:0] fa_addr = '0, pv_addr = '0;
    logic [31:0] fw_data = '0, pv_data = '0;

    // slave + per-cycle comparison against the model
    always @(negedge aclk) begin
        if (!aresetn) begin
            m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
            aw_got = 0; w_got = 0; aw_f = 0; w_f = 0; b_f = 0; b_wait = 0; w_wait = 0;
            pv_aw = 0; pv_w = 0;
        end else begin
            if (cmd_seq != last_seq) begin
                last_seq = cmd_seq; aw_i = 0; w_i = 0; wr_num = 0; done_cnt = 0;
                n_rise = 0; n_b = 0; saw_split = 0;
            end
            // consequences of the handshakes at the previous rising edge
            if (aw_f) begin
                if (aw_i < exp_addr.size()) chk($sformatf("awaddr[%0d]", aw_i), 32'(fa_addr), 32'(exp_addr[aw_i]));
                else chk("aw_beyond_model", 32'(aw_i), 32'(exp_addr.size() - 1));
                if (aw_i < 8) cap_addr[aw_i] = fa_addr;
                aw_i++; aw_got = 1;
            end
            if (w_f) begin
                if (w_i < exp_data.size()) chk($sformatf("wdata[%0d]", w_i), fw_data, exp_data[w_i]);
                else chk("w_beyond_model", 32'(w_i), 32'(exp_data.size() - 1));
                if (w_i < 8) cap_data[w_i] = fw_data;
                w_i++; w_got = 1;
            end
            if (b_f) begin
                m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
                if (n_b < 8) b_cyc[n_b] = cyc;
                n_b++; wr_num++;
            end
            // protocol checks on the current outputs
            if (pv_aw && !aw_f) begin
                chk("awvalid_hold", 32'(m_axi_awvalid), 32'd1);
                chk("awaddr_stable", 32'(m_axi_awaddr), 32'(pv_addr));
            end
            if (pv_w && !w_f) begin
                chk("wvalid_hold", 32'(m_axi_wvalid), 32'd1);
                chk("wdata_stable", m_axi_wdata, pv_data);
            end
            if (m_axi_wvalid) chk("wstrb", 32'(m_axi_wstrb), 32'hF);
            if (m_axi_awvalid || m_axi_wvalid || m_axi_bready) chk("busy_in_xfer", 32'(busy), 32'd1);
            if (m_axi_awvalid && !pv_aw) begin
                if (n_rise < 8) rise_cyc[n_rise] = cyc;
                n_rise++;
            end
            if (!m_axi_awvalid && m_axi_wvalid) saw_split = 1;
            if (done) done_cnt++;
            pv_aw = m_axi_awvalid; pv_addr = m_axi_awaddr;
            pv_w = m_axi_wvalid;   pv_data = m_axi_wdata;
            // drive the slave for the next rising edge
            case (mode)
                0: begin m_axi_awready = 1'b1; m_axi_wready = 1'b1; end
                1: begin
                    m_axi_awready = 1'($urandom_range(0, 1));
                    m_axi_wready  = 1'($urandom_range(0, 1));
                end
                default: begin
                    m_axi_awready = 1'b1;
                    if (!aw_got) m_axi_wready = 1'b0;
                    else if (w_wait < 3) begin w_wait++; m_axi_wready = 1'b0; end
                    else m_axi_wready = 1'b1;
                end
            endcase
            if (aw_got && w_got && !m_axi_bvalid) begin
                if (b_wait > 0) b_wait--;
                else begin
                    m_axi_bvalid = 1'b1;
                    m_axi_bresp  = (wr_num == err_at) ? 2'b10 : 2'b00;
                    aw_got = 0; w_got = 0; w_wait = 0;
                    b_wait = (mode == 1) ? $urandom_range(0, 3) : 0;
                end
            end
            aw_f = m_axi_awvalid && m_axi_awready; fa_addr = m_axi_awaddr;
            w_f  = m_axi_wvalid && m_axi_wready;   fw_data = m_axi_wdata;
            b_f  = m_axi_bvalid && m_axi_bready;
        end
    end

    // write list implied by a command
    task automatic build_exp(input bit stp, input logic [15:0] h, input logic [15:0] w,
                             input logic [7:0] p, input int e_at, input int s_at);
        logic [31:0] vals[4];
        exp_addr.delete(); exp_data.delete(); exp_err = 1'b0;
        vals[0] = {16'h0, h}; vals[1] = {16'h0, w}; vals[2] = {24'h0, p}; vals[3] = 32'h81;
        if (stp) begin
            exp_addr.push_back(12'h000); exp_data.push_back(32'h0);
            exp_err = (e_at == 0);
        end else if (h == 0 || w == 0) begin
            exp_err = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                exp_addr.push_back((k < 3) ? 12'(16 + 8 * k) : 12'h000);
                exp_data.push_back(vals[k]);
                if (e_at == k) begin exp_err = 1'b1; break; end
                if (s_at == k) begin
                    exp_addr.push_back(12'h000); exp_data.push_back(32'h0);
                    exp_err = (e_at == k + 1);
                    break;
                end
            end
        end
        exp_done = !exp_err && (exp_addr.size() > 0);
    endtask

    task automatic run_cmd(input bit stp, input logic [15:0] h, input logic [15:0] w,
                           input logic [7:0] p, input int e_at, input int s_at, input int md);
        int n;
        build_exp(stp, h, w, p, e_at, s_at);
        err_at = e_at; mode = md; cmd_seq++;
        @(posedge aclk); #1;
        cfg_height = h; cfg_width = w; cfg_pattern = p;
        if (stp) cfg_stop = 1'b1; else cfg_start = 1'b1;
        st_cyc = cyc + 1;
        @(posedge aclk); #1;
        cfg_start = 1'b0; cfg_stop = 1'b0;
        if (s_at >= 0) begin
            n = 0;
            while (!(m_axi_awvalid && aw_i == s_at) && n < 2000) begin @(posedge aclk); #1; n++; end
            chk("stop_trigger_reached", 32'(n < 2000), 32'd1);
            cfg_stop = 1'b1;
            @(posedge aclk); #1;
            cfg_stop = 1'b0;
        end
        n = 0;
        while (busy && n < 3000) begin @(posedge aclk); #1; n++; end
        chk("cmd_completes", 32'(n < 3000), 32'd1);
        repeat (4) @(posedge aclk);
        #1;
        chk("n_aw", 32'(aw_i), 32'(exp_addr.size()));
        chk("n_w", 32'(w_i), 32'(exp_data.size()));
        chk("done_pulses", 32'(done_cnt), 32'(exp_done));
        chk("error", 32'(error), 32'(exp_err));
        chk("busy_end", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] h, w;
        logic [7:0]  p;
        int          e, s, sel, n;
        bit          stp;

        #23;
        chk("rst_busy", 32'(busy), 0);       chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);     chk("rst_awvalid", 32'(m_axi_awvalid), 0);
        chk("rst_wvalid", 32'(m_axi_wvalid), 0); chk("rst_bready", 32'(m_axi_bready), 0);
        chk("rst_awaddr", 32'(m_axi_awaddr), 0); chk("rst_wdata", m_axi_wdata, 0);
        chk("rst_wstrb", 32'(m_axi_wstrb), 32'hF);
        @(negedge aclk); aresetn = 1'b1;
        repeat (2) @(posedge aclk);

        // basic run, always-ready slave
        run_cmd(0, 16'd600, 16'd800, 8'd9, -1, -1, 0);
        chk("first_aw_latency", 32'(rise_cyc[0] - st_cyc), 32'd9);
        chk("gap_ge_9", 32'((rise_cyc[3] - b_cyc[2]) >= 9), 32'd1);
        chk("lit_addr0", 32'(cap_addr[0]), 32'h010); chk("lit_data0", cap_data[0], 32'd600);
        chk("lit_addr1", 32'(cap_addr[1]), 32'h018); chk("lit_data1", cap_data[1], 32'd800);
        chk("lit_addr2", 32'(cap_addr[2]), 32'h020); chk("lit_data2", cap_data[2], 32'd9);
        chk("lit_addr3", 32'(cap_addr[3]), 32'h000); chk("lit_data3", cap_data[3], 32'h81);

        // wready lags awready by 3 cycles
        run_cmd(0, 16'd1080, 16'd1920, 8'd3, -1, -1, 2);
        chk("aw_w_split_seen", 32'(saw_split), 32'd1);

        // SLVERR on the width write, then a clean start clears error
        run_cmd(0, 16'd480, 16'd640, 8'd1, 1, -1, 0);
        chk("lit_err_nwrites", 32'(aw_i), 32'd2);
        run_cmd(0, 16'd480, 16'd640, 8'd1, -1, -1, 0);

        // stop during the height write
        run_cmd(0, 16'd720, 16'd1280, 8'd5, -1, 0, 0);
        chk("lit_stop_addr", 32'(cap_addr[1]), 32'h000); chk("lit_stop_data", cap_data[1], 32'h0);

        // zero-size reject, then stop from idle
        run_cmd(0, 16'd100, 16'd0, 8'd2, -1, -1, 0);
        run_cmd(1, 16'd0, 16'd0, 8'd0, -1, -1, 0);

        // asynchronous reset while awvalid is high
        build_exp(0, 16'd600, 16'd800, 8'd9, -1, -1);
        err_at = -1; mode = 0; cmd_seq++;
        @(posedge aclk); #1;
        cfg_height = 16'd600; cfg_width = 16'd800; cfg_pattern = 8'd9; cfg_start = 1'b1;
        @(posedge aclk); #1; cfg_start = 1'b0;
        n = 0;
        while (!m_axi_awvalid && n < 100) begin @(posedge aclk); #1; n++; end
        chk("mid_aw_reached", 32'(n < 100), 32'd1);
        #2 aresetn = 1'b0;
        #1;
        chk("arst_awvalid", 32'(m_axi_awvalid), 0); chk("arst_wvalid", 32'(m_axi_wvalid), 0);
        chk("arst_busy", 32'(busy), 0);             chk("arst_bready", 32'(m_axi_bready), 0);
        chk("arst_awaddr", 32'(m_axi_awaddr), 0);   chk("arst_wdata", m_axi_wdata, 0);
        @(negedge aclk); #1 aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        run_cmd(0, 16'd600, 16'd800, 8'd9, -1, -1, 1);

        // randomized commands against the model
        for (int it = 0; it < 25; it++) begin
            h = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 2000));
            w = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 2000));
            p = 8'($urandom);
            sel = $urandom_range(0, 2); e = -1; s = -1;
            if (sel == 1) e = $urandom_range(0, 3);
            else if (sel == 2) s = $urandom_range(0, 3);
            stp = ($urandom_range(0, 7) == 0);
            if (stp || h == 0 || w == 0) s = -1;
            run_cmd(stp, h, w, p, e, s, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tpg_cfg_sequencer.md
Name: tpg_cfg_sequencer

Overview:
- AXI4-Lite write-only master that replaces the simulation VIP for TPG bring-up in the AXI4S-to-video-out pipeline.
- On a start request it programs the TPG in a fixed order: active height, active width, background pattern ID, then control (ap_start plus auto_restart, i.e. free-running).
- On a stop request it writes 0x00 to the TPG control register.
- Reports busy/done/error status to the surrounding logic.

Parameters:
- ADDR_W, 12, AXI4-Lite address width.
- BASE_ADDR, 12'h000, TPG register base; register offsets are H=0x10, W=0x18, BG=0x20, CTRL=0x00.
- START_DLY, 8, aclk cycles waited after a start is accepted before the first write (200 ns at 40 MHz).
- GAP_DLY, 8, aclk cycles waited between the B response of the BG write and the CTRL write.
- CTRL_RUN, 8'h81, value written to CTRL to start the TPG.

Ports:
- aclk  in  1  clock, 40 MHz video/control clock.
- aresetn  in  1  asynchronous active-low reset.
- cfg_start  in  1  single-cycle start request.
- cfg_stop  in  1  single-cycle stop request.
- cfg_height  in  16  active height; sampled when cfg_start is accepted.
- cfg_width  in  16  active width; sampled when cfg_start is accepted.
- cfg_pattern  in  8  background pattern ID; sampled when cfg_start is accepted.
- busy  out  1  high while a sequence or stop write is in progress.
- done  out  1  one-cycle pulse when a run or stop sequence completes with OKAY.
- error  out  1  sticky; set on a non-OKAY bresp or zero height/width; cleared on the next accepted start or stop.
- m_axi_awaddr  out  ADDR_W  write address.
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_wdata  out  32  zero-extended register value.
- m_axi_wstrb  out  4  always 4'hF.
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1

Behaviour:
- Clocking and reset: one clock domain (aclk); aresetn is asynchronous active-low.
- Reset values: every output is 0 (busy, done, error, awvalid, wvalid, bready, awaddr, wdata); wstrb is 4'hF. The FSM goes to IDLE and the write index is cleared.
- Reset mid-transaction is allowed; the TPG shares aresetn.
- FSM states: IDLE, DLY, ISSUE, WAIT_B, GAP, FIN.
- IDLE, on cfg_start:
  - If height==0 or width==0: set error, pulse nothing, stay in IDLE.
  - Otherwise: latch the three values, clear error, set index=0, busy=1, load the counter with START_DLY, go to DLY.
- IDLE, on cfg_stop: clear error, set index=3 in stop mode (data 0x00), busy=1, go directly to ISSUE with no delay.
- cfg_start and cfg_stop in the same IDLE cycle: stop wins.
- Start received while busy: ignored.
- Stop received while busy: latched as stop_pend.
- DLY: counter decrements each cycle; go to ISSUE on the cycle it reaches 0.
- ISSUE:
  - awvalid and wvalid rise together.
  - Address and data by index:
    - 0: addr BASE+0x10, data height.
    - 1: addr BASE+0x18, data width.
    - 2: addr BASE+0x20, data pattern.
    - 3: addr BASE+0x00, data CTRL_RUN (or 0x00 in stop mode).
  - Each valid drops independently on the cycle its ready is sampled high; addr and data stay stable while valid.
  - When both handshakes are complete (same cycle or different cycles), go to WAIT_B with bready=1.
- WAIT_B: on bvalid, bready drops the next cycle.
  - bresp != 2'b00: set error, busy=0, go to IDLE; no done pulse, and remaining writes are skipped.
  - OKAY with stop_pend and not already in stop mode: clear stop_pend, switch to stop mode, index=3, go to ISSUE.
  - OKAY with index<2: index+1, go to ISSUE.
  - OKAY with index==2: load GAP_DLY, go to GAP.
  - OKAY with index==3: go to FIN.
- GAP: counts down like DLY, then index=3, go to ISSUE.
- FIN: done=1 for exactly one cycle, busy=0, go to IDLE.
- Handshake timing: aw/w valid never asserts before the cycle after entering ISSUE. At most one outstanding transaction. No timeout; the sequencer waits indefinitely for ready or bvalid.
- Width rules: 16-bit inputs are zero-extended to 32 bits; the 8-bit pattern is zero-extended.

Test Plan:
- Run sequence: start with H=600, W=800, P=9 and always-ready slave, OKAY responses.
  - Writes seen in order: (0x010,600), (0x018,800), (0x020,9), (0x000,0x81).
  - First awvalid appears 8+1 cycles after start; at least 8 idle cycles between the BG bresp and the CTRL awvalid.
  - done pulses once; busy then falls.
- Independent ready handshakes: slave holds wready low 3 cycles after awready.
  - awvalid drops alone, wvalid persists, and wdata stays stable until wready.
  - Sequence completes correctly.
- Error path: slave returns SLVERR on the width write.
  - No BG or CTRL write issued; error=1, done never pulses, busy=0.
  - A following good start clears error.
- Stop while busy: stop pulsed during the height write.
  - Height write completes, then a single write (0x000,0x00) follows.
  - Width and BG writes skipped; done pulses once.
- Zero-size reject and idle stop:
  - Start with W=0: error=1, no AXI activity.
  - Then stop from IDLE: exactly one (0x000,0x00) write, and done pulses.
- Async reset mid-write: aresetn low while awvalid=1.
  - All outputs go to 0 immediately (without waiting for an aclk edge).
  - After release, a new start runs the full sequence.
